// File: rtl/det_event_capture.sv
// det_event_capture
//
// Consumes the one-cycle detect pulse of the serial 10110 sequence detector.
// Each detection is timestamped with a free-running cycle counter. The
// timestamp is queued in a small first-word-fall-through FIFO, and the FIFO
// is read out over a valid/ready handshake. The block also keeps a saturating
// detection count, a sticky overflow flag and a level interrupt.
//
// Optional feature (macro DET_HOLDOFF_EN):
//   If the macro is defined, a two-state ARMED/HOLD FSM suppresses detections
//   for HOLDOFF cycles after each accepted one. If the macro is not defined,
//   every det_in=1 cycle is an event.
//
// Handshake: the head entry transfers on any rising edge with rd_valid=1 and
//   rd_ready=1. rd_valid depends only on FIFO state and never on rd_ready.
//   rd_ts is stable while rd_valid=1 and no pop occurs.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active low
//   det_in      in   detect pulse, sampled every rising edge
//   clr         in   synchronous soft clear, active high; same effect as rst
//   rd_ready    in   consumer accepts the head entry
//   rd_valid    out  FIFO not empty
//   rd_ts       out  timestamp at the FIFO head (TS_W bits)
//   fifo_level  out  entries held, 0..DEPTH ($clog2(DEPTH)+1 bits)
//   det_count   out  accepted detections, saturating (CNT_W bits)
//   overflow    out  sticky: a detection was dropped because the FIFO was full
//   irq         out  level interrupt, equal to rd_valid
//
// Debug visibility: hold_state (only if DET_HOLDOFF_EN is defined) and the
// FIFO pointers are plain named internal signals, so a checker can bind to them.

module det_event_capture #(
    parameter int TS_W    = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         det_count,
    output logic                     overflow,
    output logic                     irq
);

    localparam int IW = $clog2(DEPTH);  // index bits
    localparam int PW = IW + 1;         // pointer bits, MSB is the wrap bit

    // Catch invalid configurations during elaboration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("det_event_capture: DEPTH must be a power of 2 and >= 2");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("det_event_capture: HOLDOFF must be >= 1");
    end

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic run;      // neither rst nor clr is active this cycle
    logic evt_en;   // detections are currently being accepted
    logic accept;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign run = rst && !clr;

`ifdef DET_HOLDOFF_EN
    // The suppression window spans HOLDOFF cycles after an accepted event.
    // The counter is loaded with HOLDOFF-1 and counts down to 0. When it is
    // at 0 the FSM re-arms for the next cycle, so the next event can be
    // accepted no earlier than edge N+HOLDOFF+1.
    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } hold_state_t;

    hold_state_t     hold_state;
    hold_state_t     hold_state_d;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_cnt_d;

    always_ff @(posedge clk) begin
        if (!run) begin
            hold_state <= ARMED;
            hold_cnt   <= '0;
        end else begin
            hold_state <= hold_state_d;
            hold_cnt   <= hold_cnt_d;
        end
    end

    always_comb begin
        hold_state_d = hold_state;
        hold_cnt_d   = hold_cnt;
        case (hold_state)
            ARMED: begin
                if (det_in) begin
                    hold_state_d = HOLD;
                    hold_cnt_d   = HC_W'(HOLDOFF - 1);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    hold_state_d = ARMED;
                end else begin
                    hold_cnt_d = hold_cnt - HC_W'(1);
                end
            end
            default: begin
                hold_state_d = ARMED;
                hold_cnt_d   = '0;
            end
        endcase
    end

    assign evt_en = (hold_state == ARMED);
`else
    assign evt_en = 1'b1;
`endif

    // FIFO status and transfer decisions
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

    assign accept = run && det_in && evt_en;
    assign pop    = run && !empty && rd_ready;
    // When a pop happens in the same cycle, a full FIFO still has room.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    // Counters, pointers, and flags
    always_ff @(posedge clk) begin
        if (!run) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            det_count <= '0;
            overflow  <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept && (det_count != {CNT_W{1'b1}})) begin
                det_count <= det_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is cleared only by rst, so rd_ts is never X. After a clr the
    // old contents stay, but rd_valid=0 masks them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[IW-1:0]] <= ts;
        end
    end

    // Outputs
    assign rd_valid   = !empty;
    assign irq        = !empty;
    assign rd_ts      = mem[rd_ptr[IW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: doc/det_event_capture.md
Name: det_event_capture

Overview:
- Sits directly downstream of the serial 10110 Mealy sequence detector and consumes its one-cycle detect pulse.
- Timestamps each detection with a free-running cycle counter and queues the timestamps in a small first-word-fall-through FIFO, read out over a valid/ready handshake.
- Keeps a saturating detection count, a sticky overflow flag and a level interrupt for the control/readout side.

Parameters:
- TS_W, 16: timestamp counter width in bits.
- DEPTH, 4: FIFO depth in entries; must be a power of 2 and at least 2.
- CNT_W, 8: width of the detection counter.
- HOLDOFF, 4: suppression window in cycles; used only when DET_HOLDOFF_EN is defined; must be at least 1.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-low reset.
- det_in  input  1  detect pulse from the sequence detector, sampled at each rising edge of clk.
- clr  input  1  synchronous soft clear, active high.
- rd_ready  input  1  consumer is ready to accept the head entry.
- rd_valid  output  1  FIFO is not empty.
- rd_ts  output  TS_W  timestamp at the FIFO head.
- fifo_level  output  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.
- det_count  output  CNT_W  count of accepted detections; saturates.
- overflow  output  1  sticky flag: a detection was dropped because the FIFO was full.
- irq  output  1  level interrupt, equal to rd_valid.

Behaviour:
- Reset and clock:
  - Reset: rst is synchronous, active-low; clock is clk.
  - While rst=0 at a rising edge: timestamp counter, FIFO pointers, det_count, overflow and the holdoff state are all cleared to 0.
  - Outputs after reset: rd_valid=0, rd_ts=0, fifo_level=0, det_count=0, overflow=0, irq=0.
- Priority: rst > clr > normal operation.
- clr=1 has the same effect as reset. det_in and rd_ready are ignored in a cycle where clr=1.
- Timestamp counter (ts):
  - Increments every cycle.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- Event: det_in=1 at a rising edge. Each such cycle is one event; back-to-back high cycles are separate events.
- Accepted event:
  - det_count increments and holds at 2^CNT_W-1 (saturates).
  - The value of ts before that edge's increment is pushed into the FIFO, provided space exists.
- Space rule: space exists if fifo_level<DEPTH, OR a pop happens in the same cycle. A push and a pop when full both occur, and the level stays at DEPTH.
- Full with no pop: the timestamp is dropped, overflow is set (sticky until rst/clr), and det_count still increments.
- Read side:
  - rd_ts shows the head entry combinationally from storage.
  - Pop happens when rd_valid && rd_ready.
  - rd_ready while empty has no effect.
  - rd_ts is don't-care when rd_valid=0, but must not be X after reset.
- Latency: an event at edge N makes rd_valid=1 and rd_ts valid in the cycle that follows edge N (one cycle).
- Simultaneous push and pop when empty: impossible, because pop requires rd_valid=1. The push alone takes effect.
- Pointers: read and write pointers are $clog2(DEPTH)+1 bits wide, the extra bit being a wrap bit.
  - empty = pointers are equal.
  - full = index bits are equal and wrap bits differ.
- fifo_level = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).

Optional Feature:
- Macro: DET_HOLDOFF_EN.
- Defined: a 2-state FSM, ARMED and HOLD.
  - ARMED: an event is accepted and moves the FSM to HOLD, loading the holdoff counter with HOLDOFF-1.
  - HOLD: det_in is ignored entirely (no count, no push, no overflow). The counter decrements each cycle. At counter=0 the FSM returns to ARMED for the next cycle.
  - Effect: an event is accepted at edge N; the next event can be accepted no earlier than edge N+HOLDOFF+1.
  - rst and clr force the FSM to ARMED.
- Not defined: no FSM and no holdoff counter; every det_in=1 cycle is an event.

Test Plan:
- Reset: hold rst=0 for 3 cycles with det_in=1 and rd_ready=1 -> all outputs stay 0. After release, ts starts from 0.
- Single event: det_in=1 at the edge where ts=5, rd_ready=0 -> next cycle rd_valid=1, rd_ts=5, fifo_level=1, det_count=1, irq=1. Raise rd_ready for one cycle -> rd_valid=0, fifo_level=0.
- Overflow: with DEPTH=4 and rd_ready=0, apply 6 single-cycle pulses -> fifo_level=4, det_count=6, overflow=1. Pop 4 entries -> the timestamps of the first 4 pulses come out in order; overflow stays 1 until clr.
- Full with simultaneous push/pop: FIFO full, det_in=1 and rd_ready=1 in the same cycle -> fifo_level stays 4, overflow stays 0, and the new timestamp appears last.
- Wrap and saturation: TS_W=4, pulse at ts=15 and again at ts=1 -> rd_ts reads 15 then 1. CNT_W=2 with 5 pulses -> det_count=3.
- Holdoff (DET_HOLDOFF_EN, HOLDOFF=4): drive the upstream detector with serial 10110110110, giving detect pulses 3 cycles apart -> only pulses 1 and 3 accepted, det_count=2. Without the macro -> all 3 pulses accepted, det_count=3.
